// File: rtl/button_event_pkg.sv
// Shared types and elaboration helpers for the button event sequencer.
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT_GAP  = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_e;

  function automatic int unsigned cycles_per_ms(input int unsigned clk_freq);
    return clk_freq / 1000;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ms_tick_timer.sv
// Millisecond prescaler plus saturating millisecond counter, both restarted by clear_i.
module ms_tick_timer
  import button_event_pkg::*;
#(
  parameter int unsigned ClkFreq = 100_000_000,
  parameter int unsigned MaxMs   = 1000,
  localparam int unsigned CntW   = $clog2(MaxMs + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  output logic            ms_stb_o,
  output logic [CntW-1:0] ms_cnt_o
);

  localparam int unsigned CyclesPerMs = cycles_per_ms(ClkFreq);
  localparam int unsigned PreW        = (CyclesPerMs > 1) ? $clog2(CyclesPerMs) : 1;
  localparam logic [PreW-1:0] PreMax  = PreW'(CyclesPerMs - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxMs);

  logic [PreW-1:0] pre_q;

  // Strobe marks the last cycle of each millisecond since the last clear.
  assign ms_stb_o = (pre_q == PreMax);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      pre_q    <= '0;
      ms_cnt_o <= '0;
    end else begin
      pre_q <= ms_stb_o ? '0 : pre_q + PreW'(1);
      if (ms_stb_o && (ms_cnt_o != CntMax)) begin
        ms_cnt_o <= ms_cnt_o + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Classifies debounced button gestures into short press, long press or double click pulses.
module button_event_ctrl
  import button_event_pkg::*;
#(
  parameter int unsigned ClkFreq       = 100_000_000,
  parameter int unsigned LongPressMs   = 1000,
  parameter int unsigned DoubleClickMs = 250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic db_level_i,
  input  logic db_tick_i,
  output logic short_press_o,
  output logic long_press_o,
  output logic double_click_o,
  output logic busy_o
);

  localparam int unsigned CyclesPerMs = cycles_per_ms(ClkFreq);
  localparam int unsigned MaxMs       = max_u(LongPressMs, DoubleClickMs);
  localparam int unsigned CntW        = $clog2(MaxMs + 1);
  localparam logic [CntW-1:0] LongLast = CntW'(LongPressMs - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(DoubleClickMs - 1);

  if (CyclesPerMs < 1) begin : g_bad_clk
    $fatal(1, "button_event_ctrl: ClkFreq gives fewer than 1 cycle per ms");
  end
  if (LongPressMs < 1) begin : g_bad_long
    $fatal(1, "button_event_ctrl: LongPressMs must be >= 1");
  end
  if (DoubleClickMs < 1) begin : g_bad_gap
    $fatal(1, "button_event_ctrl: DoubleClickMs must be >= 1");
  end

  state_e          state_q;
  state_e          state_n;
  logic            level_q;
  logic            fall;
  logic            ms_stb;
  logic [CntW-1:0] ms_cnt;
  logic            timer_clear;
  logic            short_n;
  logic            long_n;
  logic            double_n;

  assign fall        = level_q & ~db_level_i;
  assign timer_clear = (state_n != state_q);

  ms_tick_timer #(
    .ClkFreq (ClkFreq),
    .MaxMs   (MaxMs)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (timer_clear),
    .ms_stb_o (ms_stb),
    .ms_cnt_o (ms_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      level_q <= 1'b0;
    end else begin
      state_q <= state_n;
      level_q <= db_level_i;
    end
  end

  // Expiry is checked before release/tick where the gesture rules give it priority.
  always_comb begin
    state_n  = state_q;
    short_n  = 1'b0;
    long_n   = 1'b0;
    double_n = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (db_tick_i) state_n = PRESS1;
      end
      PRESS1: begin
        if (ms_stb && (ms_cnt == LongLast)) begin
          long_n  = 1'b1;
          state_n = LONG_HOLD;
        end else if (fall) begin
          state_n = WAIT_GAP;
        end
      end
      WAIT_GAP: begin
        if (db_tick_i) begin
          state_n = PRESS2;
        end else if (ms_stb && (ms_cnt == GapLast)) begin
          short_n = 1'b1;
          state_n = IDLE;
        end
      end
      PRESS2: begin
        if (fall) begin
          double_n = 1'b1;
          state_n  = IDLE;
        end
      end
      LONG_HOLD: begin
        if (!db_level_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      short_press_o  <= 1'b0;
      long_press_o   <= 1'b0;
      double_click_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      short_press_o  <= short_n;
      long_press_o   <= long_n;
      double_click_o <= double_n;
      busy_o         <= (state_n != IDLE);
    end
  end

endmodule
